// File: rtl/usb_ep_in_streamer_pkg.sv
// Shared endpoint definitions for the banked USB IN endpoint.
//   - IN status view bit positions (ctrl_rd_data when ctrl_dir_in = 1)
//   - Command word bit positions (ctrl_wr_data)
//   - Handshake codes reported by the endpoint
//   - cmd_word(): assembles a command word with the byte count in [14:8]
package usb_ep_in_streamer_pkg;

   // IN status view
   localparam int ST_BUSY   = 0;   // both banks occupied
   localparam int ST_EMPTY  = 1;
   localparam int ST_STALL  = 3;
   localparam int ST_TOGGLE = 4;
   localparam int ST_BANK   = 5;

   // Command word
   localparam int CMD_COMMIT = 0;
   localparam int CMD_STALL  = 3;
   localparam int CMD_SET_T1 = 4;
   localparam int CMD_SET_T0 = 5;

   typedef enum logic [1:0] {
      HS_ACK   = 2'b00,
      HS_NAK   = 2'b01,
      HS_STALL = 2'b10,
      HS_NONE  = 2'b11
   } ep_hs_e;

   // Byte count sits in [14:8]; bit 15 is reserved and kept low.
   function automatic logic [15:0] cmd_word(input logic       commit,
                                            input logic       stall,
                                            input logic       set_t1,
                                            input logic       set_t0,
                                            input logic [6:0] cnt);
      logic [15:0] w;
      w             = '0;
      w[14:8]       = cnt;
      w[CMD_COMMIT] = commit;
      w[CMD_STALL]  = stall;
      w[CMD_SET_T1] = set_t1;
      w[CMD_SET_T0] = set_t0;
      return w;
   endfunction

endpackage

// File: rtl/usb_ep_in_streamer.sv
// usb_ep_in_streamer
// Packetizes a fabric byte stream into the IN endpoint packet buffer and
// commits each packet through the endpoint control port.
//
// Parameters
//   MAX_PKT        packet size limit in bytes (1..64)
//   FLUSH_TIMEOUT  idle cycles after the last accepted byte before a short
//                  packet is committed (>= 1)
//   ZLP_EN         append a zero-length packet after a transfer whose final
//                  packet is exactly MAX_PKT bytes
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   en             permits starting new packets
//   s_data/s_valid/s_last/s_ready   byte stream in
//   buf_addr/buf_data/buf_we        packet buffer write port (current bank)
//   ctrl_dir_in    tied 1, selects the IN status view
//   ctrl_rd_data   endpoint status
//   ctrl_wr_data/ctrl_wr_en         endpoint command write
//   pkt_sent       one-cycle pulse per commit
//   busy           high whenever not idle
module usb_ep_in_streamer
   import usb_ep_in_streamer_pkg::*;
#(
   parameter int MAX_PKT       = 64,
   parameter int FLUSH_TIMEOUT = 255,
   parameter bit ZLP_EN        = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [6:0]  buf_addr,
   output logic [7:0]  buf_data,
   output logic        buf_we,
   output logic        ctrl_dir_in,
   input  logic [15:0] ctrl_rd_data,
   output logic [15:0] ctrl_wr_data,
   output logic [1:0]  ctrl_wr_en,
   output logic        pkt_sent,
   output logic        busy
);

   localparam int                TMR_W   = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [6:0]        MAX_CNT = 7'(MAX_PKT);
   localparam logic [TMR_W-1:0]  TMO     = TMR_W'(FLUSH_TIMEOUT);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] v);
      return (v == {TMR_W{1'b1}}) ? v : v + TMR_W'(1);
   endfunction

   logic [1:0]       state_q, state_d;
   logic [6:0]       cnt_q,   cnt_d;
   logic [TMR_W-1:0] tmr_q,   tmr_d;
   logic             zlp_q,   zlp_d;

   logic accept;
   logic start_ok;

   // Only the busy and stall bits steer this block; the rest of the status
   // view is intentionally ignored.
   logic unused_status;
   assign unused_status = ^{ctrl_rd_data[15:ST_BANK+1], ctrl_rd_data[ST_BANK],
                            ctrl_rd_data[ST_TOGGLE], ctrl_rd_data[2],
                            ctrl_rd_data[ST_EMPTY]};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tmr_d        = tmr_q;
      zlp_d        = zlp_q;
      s_ready      = 1'b0;
      buf_we       = 1'b0;
      ctrl_wr_en   = 2'b00;
      ctrl_wr_data = 16'h0000;
      pkt_sent     = 1'b0;
      accept       = 1'b0;
      start_ok     = en && !ctrl_rd_data[ST_STALL] && !ctrl_rd_data[ST_BUSY];

      case (state_q)
         S_IDLE: begin
            // A pending zero-length packet goes out before any new data.
            if (start_ok && zlp_q) begin
               state_d = S_COMMIT;
            end else if (start_ok && s_valid) begin
               state_d = S_FILL;
            end
         end

         S_FILL: begin
            s_ready = (cnt_q < MAX_CNT);
            accept  = s_valid && s_ready;
            buf_we  = accept;
            if (accept) begin
               cnt_d = cnt_q + 7'd1;
               tmr_d = '0;
               if (s_last || (cnt_d == MAX_CNT)) begin
                  state_d = S_COMMIT;
               end
               if (ZLP_EN && s_last && (cnt_d == MAX_CNT)) begin
                  zlp_d = 1'b1;
               end
            end else if (cnt_q != 7'd0) begin
               // Flush a short packet once the stream has gone quiet long
               // enough; an empty fill waits indefinitely.
               tmr_d = tmr_sat_inc(tmr_q);
               if (tmr_d == TMO) begin
                  state_d = S_COMMIT;
               end
            end
         end

         S_COMMIT: begin
            ctrl_wr_en   = 2'b11;
            ctrl_wr_data = cmd_word(1'b1, 1'b0, 1'b0, 1'b0, cnt_q);
            pkt_sent     = 1'b1;
            cnt_d        = '0;
            tmr_d        = '0;
            // Only the zero-length commit carries a count of zero; the full
            // packet that armed it still has cnt == MAX_PKT here.
            if (cnt_q == 7'd0) begin
               zlp_d = 1'b0;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tmr_q   <= '0;
         zlp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         zlp_q   <= zlp_d;
      end
   end

   assign buf_addr    = cnt_q;
   assign buf_data    = s_data;
   assign ctrl_dir_in = 1'b1;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_ep_in_streamer.sv
// Scoreboard bench for usb_ep_in_streamer (MAX_PKT=8, FLUSH_TIMEOUT=10).
// A transfer-level model pushes expected buffer writes and commit counts as
// stimulus is issued; a negedge monitor pops and compares them. A second
// instance with ZLP_EN=0 covers the no-ZLP case.
module tb_usb_ep_in_streamer;

   localparam int MAXP = 8;
   localparam int TMO  = 10;
   localparam bit ZLP1 = 1'b1;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, s_valid, s_last;
   logic [7:0]  s_data;
   logic        s_ready, buf_we, ctrl_dir_in, pkt_sent, busy;
   logic [6:0]  buf_addr;
   logic [7:0]  buf_data;
   logic [15:0] status, ctrl_wr_data;
   logic [1:0]  ctrl_wr_en;

   logic        s2_valid, s2_last, s2_ready, sent2;
   logic [7:0]  s2_data;
   logic [15:0] w2_data;
   logic [6:0]  unused_b2_addr;
   logic [7:0]  unused_b2_data;
   logic        unused_b2_we, unused_dir2, unused_busy2;
   logic [1:0]  unused_w2_en;

   usb_ep_in_streamer #(.MAX_PKT(MAXP), .FLUSH_TIMEOUT(TMO), .ZLP_EN(ZLP1)) dut (
      .clk(clk), .rst(rst), .en(en),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
      .ctrl_dir_in(ctrl_dir_in), .ctrl_rd_data(status),
      .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_en(ctrl_wr_en),
      .pkt_sent(pkt_sent), .busy(busy)
   );

   usb_ep_in_streamer #(.MAX_PKT(MAXP), .FLUSH_TIMEOUT(TMO), .ZLP_EN(1'b0)) dut_nozlp (
      .clk(clk), .rst(rst), .en(1'b1),
      .s_data(s2_data), .s_valid(s2_valid), .s_last(s2_last), .s_ready(s2_ready),
      .buf_addr(unused_b2_addr), .buf_data(unused_b2_data), .buf_we(unused_b2_we),
      .ctrl_dir_in(unused_dir2), .ctrl_rd_data(16'h0002),
      .ctrl_wr_data(w2_data), .ctrl_wr_en(unused_w2_en),
      .pkt_sent(sent2), .busy(unused_busy2)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_commit = 0;
   logic [14:0] exp_wr_q[$];
   int          exp_cnt_q[$];
   logic [15:0] q2[$];
   bit          rand_env = 1'b0;

   function automatic void check(string name, longint act, longint expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endfunction

   // Scoreboard monitor
   logic [14:0] mon_e;
   int          mon_c;
   always @(negedge clk) begin
      if (buf_we) begin
         if (exp_wr_q.size() == 0) begin
            check("unexpected_write", buf_we, 0);
         end else begin
            mon_e = exp_wr_q.pop_front();
            check("buf_addr", buf_addr, mon_e[14:8]);
            check("buf_data", buf_data, mon_e[7:0]);
         end
      end
      if (pkt_sent || (ctrl_wr_en != 2'b00)) begin
         n_commit++;
         if (exp_cnt_q.size() == 0) begin
            check("unexpected_commit", pkt_sent | (|ctrl_wr_en), 0);
         end else begin
            mon_c = exp_cnt_q.pop_front();
            check("commit_word", ctrl_wr_data, {1'b0, 7'(mon_c), 8'h01});
            check("commit_wr_en", ctrl_wr_en, 3);
            check("commit_pulse", pkt_sent, 1);
         end
      end
      if (sent2) q2.push_back(w2_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_env) begin
         status[0] = ($urandom_range(0, 3) == 0);
         en        = ($urandom_range(0, 5) != 0);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input bit l, output int waits);
      bit hs;
      s_data = d; s_last = l; s_valid = 1'b1; waits = 0;
      forever begin
         hs = s_ready;
         tick();
         if (hs) break;
         waits++;
         if (waits > 2000) begin
            check("handshake_timeout", waits, 0);
            break;
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   // Transfer-level model: byte i lands at i mod MAXP; a commit of MAXP per
   // full packet, the remainder on s_last (or on flush when tail is set), and
   // a zero-length packet after a last byte that fills a packet exactly.
   task automatic send_transfer(input int len, input bit last, input int gapmax, input bit tail);
      int w;
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = 8'($urandom);
         exp_wr_q.push_back({7'(i % MAXP), d});
         if ((i + 1) % MAXP == 0) begin
            exp_cnt_q.push_back(MAXP);
            if (last && i == len - 1 && ZLP1) exp_cnt_q.push_back(0);
         end else if (last && i == len - 1) begin
            exp_cnt_q.push_back((i + 1) % MAXP);
         end
         send_byte(d, last && (i == len - 1), w);
         repeat ($urandom_range(0, gapmax)) tick();
      end
      if (!last && tail && (len % MAXP != 0)) exp_cnt_q.push_back(len % MAXP);
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((exp_wr_q.size() != 0 || exp_cnt_q.size() != 0) && k < 1000) begin
         tick();
         k++;
      end
      check(name, exp_wr_q.size() + exp_cnt_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_buf_we"}, buf_we, 0);
      check({tag, "_ctrl_wr_en"}, ctrl_wr_en, 0);
      check({tag, "_ctrl_wr_data"}, ctrl_wr_data, 0);
      check({tag, "_pkt_sent"}, pkt_sent, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ctrl_dir_in"}, ctrl_dir_in, 1);
      check({tag, "_buf_addr"}, buf_addr, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, w, k, viol;
      bit hs;
      rst = 1'b1; en = 1'b1; status = 16'h0002;
      s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
      s2_valid = 1'b0; s2_last = 1'b0; s2_data = 8'h00;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // 20 bytes: 8, 8, 4
      c0 = n_commit;
      send_transfer(20, 1'b1, 0, 1'b1);
      wait_drain("drain_20B");
      check("commits_20B", n_commit - c0, 3);

      // 16 bytes with ZLP: 8, 8, 0
      c0 = n_commit;
      send_transfer(16, 1'b1, 0, 1'b1);
      wait_drain("drain_16B_zlp");
      check("commits_16B_zlp", n_commit - c0, 3);

      // Both banks occupied: nothing accepted, nothing written
      status[0] = 1'b1; s_data = 8'hA5; s_last = 1'b1; s_valid = 1'b1;
      viol = 0;
      repeat (50) begin
         tick();
         if (s_ready || (ctrl_wr_en != 2'b00) || busy) viol++;
      end
      check("banks_full_block", viol, 0);
      status[0] = 1'b0;
      exp_wr_q.push_back({7'd0, 8'hA5});
      exp_cnt_q.push_back(1);
      send_byte(8'hA5, 1'b1, w);
      check("release_latency", w, 1);
      wait_drain("drain_release");

      // Flush timeout on a 3-byte short packet
      send_transfer(3, 1'b0, 0, 1'b1);
      k = 0;
      while (!pkt_sent && k < 100) begin
         tick();
         k++;
      end
      check("flush_latency", k, TMO);
      wait_drain("drain_flush");

      // Stall in IDLE blocks the start; clearing it resumes
      status[3] = 1'b1; s_data = 8'h3C; s_last = 1'b0; s_valid = 1'b1;
      viol = 0;
      repeat (20) begin
         tick();
         if (s_ready || busy || buf_we) viol++;
      end
      check("stall_block", viol, 0);
      s_valid = 1'b0;
      status[3] = 1'b0;
      send_transfer(5, 1'b1, 1, 1'b1);
      wait_drain("drain_after_stall");

      // Reset mid-fill discards the partial packet
      c0 = n_commit;
      send_transfer(5, 1'b0, 0, 1'b0);
      rst = 1'b1;
      tick();
      check_reset_outputs("midfill_rst");
      rst = 1'b0;
      repeat (2 * TMO) tick();
      check("midfill_no_commit", n_commit - c0, 0);
      send_transfer(8, 1'b1, 0, 1'b1);
      wait_drain("drain_after_rst");

      // Randomized transfers with random endpoint back-pressure and enable
      rand_env = 1'b1;
      for (int t = 0; t < 25; t++) begin
         send_transfer($urandom_range(1, 20), 1'b1, 3, 1'b1);
      end
      rand_env = 1'b0;
      status[0] = 1'b0; en = 1'b1;
      wait_drain("drain_random");

      // No-ZLP instance: 16 bytes give exactly two commits of 8
      for (int i = 0; i < 16; i++) begin
         s2_data = 8'(i); s2_last = (i == 15); s2_valid = 1'b1;
         k = 0;
         do begin
            hs = s2_ready;
            tick();
            k++;
         end while (!hs && k < 100);
      end
      s2_valid = 1'b0; s2_last = 1'b0;
      repeat (30) tick();
      check("nozlp_commit_count", q2.size(), 2);
      if (q2.size() >= 2) begin
         check("nozlp_word0", q2[0], 16'h0801);
         check("nozlp_word1", q2[1], 16'h0801);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
